i2c_poll_sched: RTL and testbench
=================================

// Module: i2c_poll_sched
// PURPOSE
//  Sequencer for the i2c_if master. Parks the master by holding its start_n low.
//  Releases start_n to run one register read, either on a periodic schedule or on demand.
//  Detects completion from the master's mode_i2c, then captures the received byte or
//  retries on NACK/timeout. Sits between system control logic and i2c_if.
// PARAMETERS
//  PERIOD     1000000  cycles between successive periodic poll starts (>= 2)
//  TIMEOUT    4096     max RUN cycles before an attempt counts as failed
//  MAX_RETRY  3        extra attempts after a failed one (0..15)
//  PARK_CYC   2        cycles start_n is held low between attempts (>= 1)
//  DONE_MODE  8'd106   mode_i2c value that marks end of transaction
// PORTS
//  clk          in   1  system clock, shared with i2c_if
//  rst_n        in   1  asynchronous active-low reset
//  en           in   1  enable periodic polling
//  trig         in   1  one-cycle request for a single poll
//  m_start_n    out  1  to i2c_if start_n; 0 = master parked at mode 0, 1 = run
//  m_mode       in   8  from i2c_if mode_i2c
//  m_err        in   1  from i2c_if _err
//  m_data       in   8  from i2c_if i2c_recv_data
//  data         out  8  last successfully read byte
//  data_valid   out  1  one-cycle pulse when data updates
//  fail         out  1  one-cycle pulse when all retries are exhausted
//  fail_timeout out  1  1 if the final failed attempt was a timeout; held until next fail/success
//  err_count    out  8  failed polls (after retries), saturating at 255
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  Reset (asynchronous): m_start_n=0, data=0, data_valid=0, fail=0, fail_timeout=0,
//   err_count=0, state=IDLE, period_cnt=0, retry=0, trig_pend=0.
//  All outputs are registered.
//  FSM
//   IDLE: m_start_n=0. Go to RUN when (en && period_cnt==0) || trig_pend.
//     On that transition: period_cnt<=PERIOD-1, trig_pend<=0, tmo_cnt<=0.
//   RUN: m_start_n=1; tmo_cnt increments each cycle.
//     - m_mode==DONE_MODE && !m_err: data<=m_data, data_valid pulse (next cycle),
//       fail_timeout<=0, retry<=0, go to PARK (no rerun).
//     - m_mode==DONE_MODE && m_err, or tmo_cnt==TIMEOUT-1: the attempt failed.
//       If retry<MAX_RETRY: retry++, PARK with rerun=1.
//       Else: fail pulse, err_count++ (saturating), fail_timeout<=(cause was timeout),
//       retry<=0, PARK with rerun=0.
//     - If DONE and timeout occur in the same cycle, DONE wins.
//   PARK: m_start_n=0 for exactly PARK_CYC cycles, then RUN (tmo_cnt<=0) if rerun,
//     else IDLE. m_mode is never compared outside RUN.
//  period_cnt: while en=1 it decrements every cycle in every state and holds at 0.
//   While en=0 it is forced to 0, so the first poll starts the cycle after en rises
//   (in IDLE).
//  Periodic start-to-start spacing is exactly PERIOD cycles if transactions are shorter.
//  If a transaction runs longer, the next poll starts on the first IDLE cycle.
//  trig: sets trig_pend in any state (no queue depth beyond 1). trig_pend is cleared
//   when RUN is entered from IDLE. Retries do not clear it.
//  en falling mid-transaction: the current poll and its retries complete; no new
//   periodic start is made.
//  Reset mid-RUN: m_start_n drops to 0 immediately, parking the master; all state clears.
// TESTING
//  1 Reset asserted mid-operation -> m_start_n=0 asynchronously; all outputs 0; busy=0.
//  2 PERIOD=200, master model reaches 106 after 80 cycles with data 0x5A -> one
//    data_valid pulse, data=0x5A, next m_start_n rise exactly 200 cycles after the first.
//  3 m_err=1 on attempts 1-2, 0 on attempt 3 -> m_start_n low exactly 2 cycles between
//    attempts, one data_valid, no fail, err_count=0.
//  4 m_err=1 always, MAX_RETRY=3 -> 4 attempts, one fail pulse, err_count=1,
//    fail_timeout=0, data unchanged.
//  5 TIMEOUT=64, m_mode stuck at 50 -> each attempt ends after 64 RUN cycles;
//    after 4 attempts, fail pulse with fail_timeout=1.
//  6 en=0, trig pulsed twice during RUN -> exactly one extra poll after PARK.
//    err_count preloaded to 255 plus one more failure -> err_count stays 255.

Source files
------------

// File: rtl/i2c_poll_sched.sv
// Poll sequencer for the i2c_if master: parks it via start_n, runs one register read
// periodically or on demand, captures the byte, and retries on NACK or timeout.
module i2c_poll_sched #(
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned PARK_CYC  = 2,
  parameter logic [7:0]  DONE_MODE = 8'd106
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       trig,
  output logic       m_start_n,
  input  logic [7:0] m_mode,
  input  logic       m_err,
  input  logic [7:0] m_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       fail,
  output logic       fail_timeout,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned PW = $clog2(PERIOD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned KW = $clog2(PARK_CYC + 1);

  typedef enum logic [1:0] {StIdle, StRun, StPark} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [KW-1:0] park_cnt_q, park_cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          rerun_q, rerun_d;
  logic          trig_pend_q, trig_pend_d;
  logic          m_start_n_q, m_start_n_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          fail_q, fail_d;
  logic          fail_timeout_q, fail_timeout_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          busy_q, busy_d;
  logic          start_poll;
  logic          mode_done;

  assign mode_done = (m_mode == DONE_MODE);

  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    park_cnt_d     = park_cnt_q;
    retry_d        = retry_q;
    rerun_d        = rerun_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    fail_d         = 1'b0;
    fail_timeout_d = fail_timeout_q;
    err_count_d    = err_count_q;
    start_poll     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((en && period_cnt_q == '0) || trig_pend_q) begin
          state_d    = StRun;
          tmo_cnt_d  = '0;
          start_poll = 1'b1;
        end
      end
      StRun: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A clean DONE takes priority over a coincident timeout.
        if (mode_done && !m_err) begin
          data_d         = m_data;
          data_valid_d   = 1'b1;
          fail_timeout_d = 1'b0;
          retry_d        = '0;
          rerun_d        = 1'b0;
          park_cnt_d     = '0;
          state_d        = StPark;
        end else if (mode_done || tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            rerun_d = 1'b1;
          end else begin
            fail_d         = 1'b1;
            fail_timeout_d = !mode_done;
            retry_d        = '0;
            rerun_d        = 1'b0;
            if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
          end
          park_cnt_d = '0;
          state_d    = StPark;
        end
      end
      StPark: begin
        if (park_cnt_q == KW'(PARK_CYC - 1)) begin
          state_d   = rerun_q ? StRun : StIdle;
          tmo_cnt_d = '0;
        end else begin
          park_cnt_d = park_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (trig)            trig_pend_d = 1'b1;
    else if (start_poll) trig_pend_d = 1'b0;
    else                 trig_pend_d = trig_pend_q;

    if (!en)                     period_cnt_d = '0;
    else if (start_poll)         period_cnt_d = PW'(PERIOD - 1);
    else if (period_cnt_q != '0) period_cnt_d = period_cnt_q - 1'b1;
    else                         period_cnt_d = period_cnt_q;

    m_start_n_d = (state_d == StRun);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      period_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      park_cnt_q     <= '0;
      retry_q        <= '0;
      rerun_q        <= 1'b0;
      trig_pend_q    <= 1'b0;
      m_start_n_q    <= 1'b0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      fail_q         <= 1'b0;
      fail_timeout_q <= 1'b0;
      err_count_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      park_cnt_q     <= park_cnt_d;
      retry_q        <= retry_d;
      rerun_q        <= rerun_d;
      trig_pend_q    <= trig_pend_d;
      m_start_n_q    <= m_start_n_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      fail_q         <= fail_d;
      fail_timeout_q <= fail_timeout_d;
      err_count_q    <= err_count_d;
      busy_q         <= busy_d;
    end
  end

  assign m_start_n    = m_start_n_q;
  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign fail         = fail_q;
  assign fail_timeout = fail_timeout_q;
  assign err_count    = err_count_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Bench for i2c_poll_sched: two instances (long/short timeout) driven by a simple
// master model; scenario table plus hand sequences for periodic, saturation and reset.
module tb_i2c_poll_sched;

  localparam int unsigned PARK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en[2], trig[2], sn[2], m_err[2], dv[2], fail[2], fto[2], busy[2];
  logic [7:0] mode[2], m_data[2], data[2], errc[2];
  int         lat[2], err_n[2];
  logic       model_rst;

  int checks = 0;
  int failures = 0;

  // Master model: mode reaches 106 once lat run cycles have elapsed; err on early attempts.
  for (genvar g = 0; g < 2; g++) begin : g_model
    int   cnt;
    int   att;
    logic prev;
    always @(posedge clk) begin
      prev <= sn[g];
      cnt  <= sn[g] ? cnt + 1 : 0;
      if (model_rst) att <= 0;
      else if (sn[g] && !prev) att <= att + 1;
    end
    assign mode[g]  = !sn[g] ? 8'd0 : ((cnt >= lat[g]) ? 8'd106 : 8'd50);
    assign m_err[g] = sn[g] && (att <= err_n[g]);
  end

  i2c_poll_sched #(
    .PERIOD(200), .TIMEOUT(128), .MAX_RETRY(3), .PARK_CYC(PARK), .DONE_MODE(8'd106)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .trig(trig[0]), .m_start_n(sn[0]),
    .m_mode(mode[0]), .m_err(m_err[0]), .m_data(m_data[0]), .data(data[0]),
    .data_valid(dv[0]), .fail(fail[0]), .fail_timeout(fto[0]), .err_count(errc[0]),
    .busy(busy[0])
  );

  i2c_poll_sched #(
    .PERIOD(50), .TIMEOUT(64), .MAX_RETRY(3), .PARK_CYC(PARK), .DONE_MODE(8'd106)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .trig(trig[1]), .m_start_n(sn[1]),
    .m_mode(mode[1]), .m_err(m_err[1]), .m_data(m_data[1]), .data(data[1]),
    .data_valid(dv[1]), .fail(fail[1]), .fail_timeout(fto[1]), .err_count(errc[1]),
    .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int w_att, w_dv, w_fail, w_park_min, w_park_max, w_run_min, w_run_max;

  // Pulse trig, then observe one poll (all attempts) until busy stays low.
  task automatic watch(input int idx, input bit trig2, input int max_cyc);
    int lowrun, runcur, idle_cnt;
    bit seen, prev, done;
    w_att = 0; w_dv = 0; w_fail = 0;
    w_park_min = 1000000; w_park_max = 0; w_run_min = 1000000; w_run_max = 0;
    lowrun = 0; runcur = 0; idle_cnt = 0; seen = 0; done = 0;
    prev = sn[idx];
    trig[idx] = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (sn[idx] && !prev) begin
        w_att++;
        if (w_att > 1) begin
          if (lowrun < w_park_min) w_park_min = lowrun;
          if (lowrun > w_park_max) w_park_max = lowrun;
        end
        runcur = 0;
      end
      if (sn[idx]) begin
        runcur++;
        lowrun = 0;
      end else begin
        if (prev) begin
          if (runcur < w_run_min) w_run_min = runcur;
          if (runcur > w_run_max) w_run_max = runcur;
        end
        lowrun++;
      end
      if (dv[idx]) w_dv++;
      if (fail[idx]) w_fail++;
      trig[idx] = (trig2 && w_att == 1 && sn[idx] && (runcur == 3 || runcur == 6));
      if (busy[idx]) begin
        seen = 1; idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      prev = sn[idx];
      if (seen && idle_cnt >= 4) begin
        done = 1;
        break;
      end
    end
    trig[idx] = 1'b0;
    chk("watch_done", done, 1);
  endtask

  task automatic pulse_model_rst();
    model_rst = 1'b1;
    @(negedge clk);
    model_rst = 1'b0;
  endtask

  typedef struct {
    int         idx;
    int         lat;
    int         err_n;
    logic [7:0] din;
    bit         trig2;
    int         exp_att;
    int         exp_dv;
    int         exp_fail;
    logic       exp_fto;
    int         exp_errc;
    logic [7:0] exp_data;
    int         exp_park;
    int         exp_run;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rise2, dvc, idle;
    bit p;

    // idx lat err_n din trig2 | att dv fail fto errc data park run
    vecs[0] = '{0, 3,    2,    8'h3C, 0, 3, 1, 0, 1'b0, 0, 8'h3C, PARK, 0};
    vecs[1] = '{0, 3,    99,   8'hA5, 0, 4, 0, 1, 1'b0, 1, 8'h3C, PARK, 0};
    vecs[2] = '{1, 1000, 0,    8'h11, 0, 4, 0, 1, 1'b1, 1, 8'h00, PARK, 64};
    vecs[3] = '{1, 5,    0,    8'hC3, 0, 1, 1, 0, 1'b0, 1, 8'hC3, 0,    0};
    vecs[4] = '{0, 20,   0,    8'h77, 1, 2, 2, 0, 1'b0, 1, 8'h77, 0,    0};

    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; trig[i] = 1'b0; m_data[i] = 8'h00; lat[i] = 4; err_n[i] = 0;
    end
    model_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start_n", sn[0], 0);
    chk("rst_data", data[0], 0);
    chk("rst_dv", dv[0], 0);
    chk("rst_fail", fail[0], 0);
    chk("rst_fto", fto[0], 0);
    chk("rst_errc", errc[0], 0);
    chk("rst_busy", busy[0], 0);
    rst_n = 1'b1;
    model_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Periodic polling on A: spacing of 200 cycles, one capture.
    pulse_model_rst();
    lat[0] = 79; err_n[0] = 0; m_data[0] = 8'h5A;
    en[0] = 1'b1;
    @(negedge clk);
    chk("period_first_start", sn[0], 1);
    rise2 = -1; dvc = 0; p = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (sn[0] && !p && rise2 < 0) rise2 = c;
      if (c < 200 && dv[0]) dvc++;
      if (c == 199) chk("period_data", data[0], 8'h5A);
      p = sn[0];
    end
    chk("period_dv_count", dvc, 1);
    chk("period_spacing", rise2, 200);
    en[0] = 1'b0;
    idle = 0;
    for (int c = 0; c < 400 && idle < 4; c++) begin
      @(negedge clk);
      idle = busy[0] ? 0 : idle + 1;
    end
    chk("period_idle", idle >= 4, 1);

    for (int v = 0; v < 5; v++) begin
      pulse_model_rst();
      lat[vecs[v].idx]    = vecs[v].lat;
      err_n[vecs[v].idx]  = vecs[v].err_n;
      m_data[vecs[v].idx] = vecs[v].din;
      watch(vecs[v].idx, vecs[v].trig2, 2000);
      chk($sformatf("v%0d_attempts", v), w_att, vecs[v].exp_att);
      chk($sformatf("v%0d_dv", v), w_dv, vecs[v].exp_dv);
      chk($sformatf("v%0d_fail", v), w_fail, vecs[v].exp_fail);
      chk($sformatf("v%0d_fto", v), fto[vecs[v].idx], vecs[v].exp_fto);
      chk($sformatf("v%0d_errc", v), errc[vecs[v].idx], vecs[v].exp_errc);
      chk($sformatf("v%0d_data", v), data[vecs[v].idx], vecs[v].exp_data);
      if (vecs[v].exp_park > 0) begin
        chk($sformatf("v%0d_park_min", v), w_park_min, vecs[v].exp_park);
        chk($sformatf("v%0d_park_max", v), w_park_max, vecs[v].exp_park);
      end
      if (vecs[v].exp_run > 0) begin
        chk($sformatf("v%0d_run_min", v), w_run_min, vecs[v].exp_run);
        chk($sformatf("v%0d_run_max", v), w_run_max, vecs[v].exp_run);
      end
    end

    // Drive A's error count to saturation, then one more failure.
    lat[0] = 2; err_n[0] = 100000;
    for (int k = 0; k < 254; k++) watch(0, 0, 200);
    chk("sat_errc_255", errc[0], 255);
    watch(0, 0, 200);
    chk("sat_fail_pulse", w_fail, 1);
    chk("sat_errc_hold", errc[0], 255);
    chk("sat_data_kept", data[0], 8'h77);

    // Reset in the middle of a RUN.
    lat[0] = 50; err_n[0] = 0;
    trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    idle = 0;
    for (int c = 0; c < 10 && !sn[0]; c++) @(negedge clk);
    chk("mid_run_started", sn[0], 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start_n", sn[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_errc", errc[0], 0);
    chk("arst_data", data[0], 0);
    chk("arst_fto", fto[0], 0);
    chk("arst_b_data", data[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_parked", sn[0], 0);
    chk("post_rst_idle", busy[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
